// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int REQ_M0 = 0;
  localparam int REQ_M1 = 1;

  localparam int DEF_DATA_W = 256;
  localparam int DEF_ADDR_W = 32;

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the requester
// that did not own the memory last (last = index of previous owner).
module dmem_arb_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot winner selection
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant[REQ_M0] = 1'b1;
      2'b10: grant[REQ_M1] = 1'b1;
      2'b11: begin
        if (last) begin
          grant[REQ_M0] = 1'b1;
        end else begin
          grant[REQ_M1] = 1'b1;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between dcache (m0) and icache (m1) with a watchdog.
// Optional feature: define ARB_LOCK_EN to keep a writing owner for one follow-up transaction.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e       state_r;
  logic [1:0]       grant_r;
  logic             mem_enable_r;
  logic             err_r;
  logic             last_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]       pick_s;
  logic             owner_en_s;
  logic             retain_s;

  dmem_arb_rr_pick u_pick (
    .req   ({m1_enable_i, m0_enable_i}),
    .last  (last_r),
    .grant (pick_s)
  );

  // Owner-side mux; everything reads as zero while no one holds the grant
  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = {ADDR_W{1'b0}};
    mem_data_o  = {DATA_W{1'b0}};
    owner_en_s  = 1'b0;
    case (grant_r)
      2'b01: begin
        mem_write_o = m0_write_i;
        mem_addr_o  = m0_addr_i;
        mem_data_o  = m0_data_i;
        owner_en_s  = m0_enable_i;
      end
      2'b10: begin
        mem_write_o = m1_write_i;
        mem_addr_o  = m1_addr_i;
        mem_data_o  = m1_data_i;
        owner_en_s  = m1_enable_i;
      end
      default: begin
        mem_write_o = 1'b0;
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_data_o  = {DATA_W{1'b0}};
        owner_en_s  = 1'b0;
      end
    endcase
  end

`ifdef ARB_LOCK_EN
  logic retained_r;

  // A write completing with enable still high keeps the owner, but only once per grant
  always_comb begin
    if (mem_ack_i && mem_write_o && owner_en_s && !retained_r) begin
      retain_s = 1'b1;
    end else begin
      retain_s = 1'b0;
    end
  end

  // Tracks whether the current grant has already used its retain
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retained_r <= 1'b0;
    end else if (state_r != GRANT) begin
      retained_r <= 1'b0;
    end else if (mem_ack_i) begin
      retained_r <= retain_s;
    end
  end
`else
  // Without the lock every ack releases the memory
  always_comb begin
    retain_s = 1'b0;
  end
`endif

  // Arbitration FSM with registered grant/enable and the sticky watchdog
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= IDLE;
      grant_r      <= 2'b00;
      mem_enable_r <= 1'b0;
      err_r        <= 1'b0;
      last_r       <= 1'b1;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (pick_s != 2'b00) begin
            state_r      <= GRANT;
            grant_r      <= pick_s;
            mem_enable_r <= 1'b1;
          end else begin
            state_r      <= IDLE;
            grant_r      <= 2'b00;
            mem_enable_r <= 1'b0;
          end
        end
        GRANT: begin
          if (mem_ack_i && retain_s) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (mem_ack_i || !owner_en_s) begin
            // Completion or abort: hand back to IDLE and remember the owner for fairness
            state_r      <= IDLE;
            grant_r      <= 2'b00;
            mem_enable_r <= 1'b0;
            last_r       <= grant_r[REQ_M1];
            cnt_r        <= {CNT_W{1'b0}};
          end else if (TIMEOUT > 0) begin
            if (cnt_r != CNT_W'(TIMEOUT)) begin
              cnt_r <= cnt_r + CNT_W'(1);
              if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                err_r <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          grant_r      <= 2'b00;
          mem_enable_r <= 1'b0;
        end
      endcase
    end
  end

  assign m0_ack_o     = mem_ack_i & grant_r[REQ_M0];
  assign m1_ack_o     = mem_ack_i & grant_r[REQ_M1];
  assign m0_data_o    = mem_data_i;
  assign m1_data_o    = mem_data_i;
  assign mem_enable_o = mem_enable_r;
  assign grant_o      = grant_r;
  assign err_o        = err_r;

endmodule
